// File: rtl/pipe_pkg.sv
// Shared definitions for the valid/ready pipeline register with skid entry.
package pipe_pkg;

    localparam int unsigned PIPE_DATA_W = 101;
    localparam int unsigned PIPE_CTRL_W = 3;

    // Occupancy-ordered states; encoding matches the held-entry count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } pipe_state_e;

    // Number of held entries for a given state.
    function automatic logic [1:0] occupancy_of(input pipe_state_e st);
        logic [1:0] n;
        n = 2'd0;
        case (st)
            EMPTY:   n = 2'd0;
            ONE:     n = 2'd1;
            TWO:     n = 2'd2;
            default: n = 2'd0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/pipe_entry.sv
// One held pipeline entry: enable-loaded register with async clear.
module pipe_entry #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] q_q;

    // Load on enable; reset clears contents so nothing stale survives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q <= '0;
        end else if (en) begin
            q_q <= d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/pipe_reg_skid.sv
// Pipeline stage register with a skid entry so in_ready depends only on state.
module pipe_reg_skid
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W = PIPE_DATA_W,
    parameter int unsigned CTRL_W = PIPE_CTRL_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    localparam int unsigned ENTRY_W = CTRL_W + DATA_W;

    pipe_state_e        state_q;
    pipe_state_e        state_d;
    logic               main_en;
    logic               skid_en;
    logic               main_from_skid;
    logic               in_fire;
    logic               out_fire;
    logic [ENTRY_W-1:0] in_entry;
    logic [ENTRY_W-1:0] main_d;
    logic [ENTRY_W-1:0] main_q;
    logic [ENTRY_W-1:0] skid_q;

    // Handshake decode purely from registered state.
    assign in_ready  = (state_q != TWO);
    assign out_valid = (state_q != EMPTY);
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;
    assign in_entry  = {in_ctrl, in_data};
    assign main_d    = main_from_skid ? skid_q : in_entry;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and entry load enables; flush overrides every transfer.
    always_comb begin
        state_d        = state_q;
        main_en        = 1'b0;
        skid_en        = 1'b0;
        main_from_skid = 1'b0;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        main_en = 1'b1;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_en = 1'b1;
                    end else if (in_fire) begin
                        skid_en = 1'b1;
                        state_d = TWO;
                    end else if (out_fire) begin
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    if (out_fire) begin
                        main_en        = 1'b1;
                        main_from_skid = 1'b1;
                        state_d        = ONE;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
    end

    pipe_entry #(.W(ENTRY_W)) u_main (
        .clk (clk),
        .rst (rst),
        .en  (main_en),
        .d   (main_d),
        .q   (main_q)
    );

    pipe_entry #(.W(ENTRY_W)) u_skid (
        .clk (clk),
        .rst (rst),
        .en  (skid_en),
        .d   (in_entry),
        .q   (skid_q)
    );

    // Bubbles carry zero control so they can never write architectural state.
    assign out_ctrl  = out_valid ? main_q[ENTRY_W-1:DATA_W] : '0;
    assign out_data  = main_q[DATA_W-1:0];
    assign occupancy = occupancy_of(state_q);

endmodule

// File: tb/tb_pipe_reg_skid.sv
// Scoreboard bench for pipe_reg_skid.
module tb_pipe_reg_skid;
    import pipe_pkg::*;

    localparam int unsigned DW = PIPE_DATA_W;
    localparam int unsigned CW = PIPE_CTRL_W;
    localparam int unsigned EW = CW + DW;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [CW-1:0] in_ctrl;
    logic [DW-1:0] in_data;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] out_ctrl;
    logic [DW-1:0] out_data;
    logic [1:0]    occupancy;

    int checks   = 0;
    int failures = 0;
    logic [EW-1:0] sb_q[$];

    always #5 clk = ~clk;

    pipe_reg_skid #(.DATA_W(DW), .CTRL_W(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctrl   (in_ctrl),
        .in_data   (in_data),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] rand_data();
        logic [127:0] r;
        r = {$urandom, $urandom, $urandom, $urandom};
        return r[DW-1:0];
    endfunction

    // Check mid-cycle, update the model for the coming edge, then advance.
    task automatic cycle();
        logic [EW-1:0] exp_e;
        @(negedge clk);
        check("occupancy", 128'(occupancy), 128'(sb_q.size()));
        check("out_valid", 128'(out_valid), 128'(sb_q.size() != 0));
        check("in_ready", 128'(in_ready), 128'(sb_q.size() != 2));
        if (!out_valid) check("bubble_ctrl", 128'(out_ctrl), 128'(0));
        if (flush) begin
            sb_q.delete();
        end else begin
            if (out_valid && out_ready && sb_q.size() != 0) begin
                exp_e = sb_q.pop_front();
                check("out_payload", 128'({out_ctrl, out_data}), 128'(exp_e));
            end
            if (in_valid && in_ready) sb_q.push_back({in_ctrl, in_data});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d);
        in_valid = v;
        in_ctrl  = c;
        in_data  = d;
    endtask

    initial begin
        int guard;
        rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
        drive(1'b1, 3'b111, DW'(5));

        // Reset holds everything clear even with valid input.
        repeat (2) @(negedge clk);
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_out_ctrl", 128'(out_ctrl), 128'(0));
        check("rst_occupancy", 128'(occupancy), 128'(0));
        check("rst_in_ready", 128'(in_ready), 128'(1));
        check("rst_out_data", 128'(out_data), 128'(0));

        // First transfer right after release, visible one cycle later.
        @(posedge clk); #1;
        rst = 1'b0;
        drive(1'b1, 3'b101, DW'(1));
        cycle();
        check("latency1_data", 128'(out_data), 128'(1));
        check("latency1_valid", 128'(out_valid), 128'(1));
        drive(1'b0, '0, '0);
        out_ready = 1'b1;
        cycle();

        // Streaming D0..D9 back to back.
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, CW'(i), DW'(32'h100 + i));
            cycle();
            check("stream_not_full", 128'(occupancy == 2'd2), 128'(0));
        end
        drive(1'b0, '0, '0);
        cycle();

        // Backpressure: A, B fill both entries, C is refused.
        out_ready = 1'b0;
        drive(1'b1, 3'd1, DW'(32'hA));
        cycle();
        drive(1'b1, 3'd2, DW'(32'hB));
        cycle();
        drive(1'b1, 3'd3, DW'(32'hC));
        cycle();
        check("bp_in_ready", 128'(in_ready), 128'(0));
        check("bp_occupancy", 128'(occupancy), 128'(2));
        check("bp_hold_data", 128'(out_data), 128'(32'hA));
        out_ready = 1'b1;
        repeat (2) cycle();
        drive(1'b0, '0, '0);
        guard = 0;
        while (sb_q.size() != 0 && guard < 20) begin
            cycle();
            guard++;
        end
        check("bp_drain_timeout", 128'(sb_q.size()), 128'(0));
        cycle();

        // Flush with both entries held and a same-cycle input E.
        out_ready = 1'b0;
        drive(1'b1, 3'd4, DW'(32'h11)); cycle();
        drive(1'b1, 3'd5, DW'(32'h22)); cycle();
        flush = 1'b1;
        drive(1'b1, 3'd7, DW'(32'hE));
        cycle();
        flush = 1'b0;
        drive(1'b0, '0, '0);
        check("flush_occupancy", 128'(occupancy), 128'(0));
        check("flush_out_valid", 128'(out_valid), 128'(0));
        check("flush_out_ctrl", 128'(out_ctrl), 128'(0));
        out_ready = 1'b1;
        repeat (3) cycle();

        // Simultaneous accept and emit while holding one entry.
        out_ready = 1'b0;
        drive(1'b1, 3'd1, DW'(32'hAA)); cycle();
        out_ready = 1'b1;
        drive(1'b1, 3'd2, DW'(32'hBB)); cycle();
        check("simul_occupancy", 128'(occupancy), 128'(1));
        check("simul_main", 128'(out_data), 128'(32'hBB));
        drive(1'b0, '0, '0);
        cycle();

        // Async reset between edges with both entries held.
        out_ready = 1'b0;
        drive(1'b1, 3'd6, DW'(32'h55)); cycle();
        drive(1'b1, 3'd3, DW'(32'h66)); cycle();
        check("pre_rst_occupancy", 128'(occupancy), 128'(2));
        #2;
        rst = 1'b1;
        #1;
        check("async_out_valid", 128'(out_valid), 128'(0));
        check("async_occupancy", 128'(occupancy), 128'(0));
        check("async_out_ctrl", 128'(out_ctrl), 128'(0));
        check("async_out_data", 128'(out_data), 128'(0));
        check("async_in_ready", 128'(in_ready), 128'(1));
        sb_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        drive(1'b0, '0, '0);
        out_ready = 1'b1;
        repeat (3) cycle();

        // Random traffic with occasional flushes.
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 3) != 0), CW'($urandom), rand_data());
            out_ready = 1'($urandom_range(0, 2) != 0);
            flush     = 1'($urandom_range(0, 39) == 0);
            cycle();
        end
        flush = 1'b0;
        drive(1'b0, '0, '0);
        out_ready = 1'b1;
        guard = 0;
        while (sb_q.size() != 0 && guard < 20) begin
            cycle();
            guard++;
        end
        check("rand_drain_timeout", 128'(sb_q.size()), 128'(0));
        cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
